// File: rtl/bitstream_serializer.sv
// Parallel-in serial-out transmitter for the bitstream lane: one WORD_W word
// becomes WORD_W/LANE_W consecutive LANE_W-bit beats, lowest pair first.
module bitstream_serializer #(
    parameter int                  WORD_W   = 12,
    parameter int                  LANE_W   = 2,
    parameter logic [LANE_W-1:0]   IDLE_PAT = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [LANE_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic              word_done
);

    localparam int BEATS = WORD_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    beat_cnt, cnt_nxt;
    logic [WORD_W-1:0]   sreg, sreg_nxt;
    logic [LANE_W-1:0]   dout_nxt;
    logic                valid_nxt, sof_nxt, done_nxt;

    // Ready in the last-beat cycle lets the next word follow with no gap.
    assign din_ready = (state == IDLE) || (state == SHIFT && beat_cnt == LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        sreg_nxt  = sreg;
        dout_nxt  = IDLE_PAT;
        valid_nxt = 1'b0;
        sof_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (din_valid && din_ready) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            sreg_nxt  = din >> LANE_W;
            dout_nxt  = din[LANE_W-1:0];
            valid_nxt = 1'b1;
            sof_nxt   = 1'b1;
            done_nxt  = (BEATS == 1);
        end else if (state == SHIFT && beat_cnt != LAST) begin
            cnt_nxt   = beat_cnt + CNT_W'(1);
            sreg_nxt  = sreg >> LANE_W;
            dout_nxt  = sreg[LANE_W-1:0];
            valid_nxt = 1'b1;
            done_nxt  = (cnt_nxt == LAST);
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            sreg       <= '0;
            dout       <= IDLE_PAT;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= cnt_nxt;
            sreg       <= sreg_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            dout_sof   <= sof_nxt;
            word_done  <= done_nxt;
        end
    end

endmodule
